mb_cam_ctl: RTL and testbench
=============================

# mb_cam_ctl

Allocation and lookup controller for the 16-entry x 40-bit miss-buffer address CAM; sits directly upstream of the CAM, driving its write and lookup ports and consuming its registered match vector. Tracks entry valid bits and an occupancy count, and picks the lowest free entry on allocate. Returns a valid-qualified, priority-encoded hit per lookup, and closes the write/lookup hazard inside the CAM with an in-flight bypass.

## Interface
- ENTRIES, 16, CAM entries; one-hot wordline width
- IDX_W, 4, encoded entry index width
- rclk  in  1  clock; all flops on posedge
- rst_l  in  1  reset, synchronous, active-low
- alloc_req  in  1  allocate request
- alloc_addr  in  40  address to store
- alloc_gnt  out  1  allocate granted (combinational, same cycle)
- alloc_idx  out  4  granted entry index
- dealloc_vld  in  1  free an entry
- dealloc_idx  in  4  entry to free
- lkup_req  in  1  lookup request
- lkup_key  in  [39:8]  lookup key
- lkup_vld  out  1  lookup result valid
- lkup_hit  out  1  qualified full-key hit
- lkup_hit_idx  out  4  lowest hitting entry
- lkup_idx_hit  out  1  any valid entry matches key[17:8]
- lkup_err  out  1  multi-hit detected (see Configuration)
- count  out  5  valid entries, 0..16
- full  out  1  count == 16
- cam_write_en  out  1  CAM write enable
- cam_adr_w  out  16  one-hot write wordline
- cam_din  out  40  CAM write data
- cam_lookup_en  out  1  CAM lookup enable
- cam_key  out  [39:8]  CAM key
- cam_match  in  16  CAM full-key match
- cam_match_idx  in  16  CAM index-field match

## Operation
- Reset (rst_l low at posedge): valid, count, all pipeline valids = 0; all cam_* and lkup_* outputs = 0; full = 0. Reset mid-lookup drops the lookup without a result.
- Allocate: alloc_gnt = alloc_req & ~full. alloc_idx = lowest clear bit of valid (0 when full). On grant: valid[idx] set, cam_write_en = 1, cam_adr_w = onehot(idx), cam_din = alloc_addr, all at next posedge.
- Deallocate: clears valid[dealloc_idx] at next posedge. Dealloc of an already-clear entry is ignored and does not change count.
- Simultaneous alloc + dealloc: both apply and count is unchanged. The two cannot collide, because alloc selects only from entries already clear.
- cam_adr_w is all-zero whenever cam_write_en = 0.
- Lookup pipeline, stage S0 (cycle N): capture key, valid snapshot vsnap = valid (pre-alloc), and bypass byp = alloc_gnt & alloc_addr[39:8]==lkup_key, with bidx = alloc_idx and a matching [17:8] compare.
- Lookup S1 (cycle N+1): cam_lookup_en = 1 and cam_key = key. Snapshot state is carried forward.
- Lookup S2 (cycle N+2): cam_match and cam_match_idx are sampled.
- Lookup S3 (cycle N+3): q = cam_match & vsnap & valid_now, OR onehot(bidx) when byp & valid_now[bidx]. lkup_hit = |q; lkup_hit_idx = lowest set bit of q (0 if none). lkup_idx_hit uses the same rule on cam_match_idx.
- The vsnap mask discards stale CAM data for entries being written while the lookup is in flight.
- The valid_now mask drops entries deallocated while the lookup is in flight.

## Timing
- Allocate: grant in cycle N. CAM write lands at posedge N+2 (the CAM re-registers internally). A lookup issued in N+1 or later sees the new data directly; a lookup issued in N is covered by the bypass.
- Lookup latency: lkup_req in cycle N gives lkup_vld high for exactly one cycle in N+3. Throughput is one lookup per cycle, with no backpressure.
- count and full update at the posedge after alloc/dealloc. full is registered from count.

## Configuration
- MB_CAM_CTL_MULTIHIT_CHK_EN defined: lkup_err = lkup_vld & (popcount(q) > 1), and a simulation $display reports the q vector.
- Not defined: lkup_err tied 0 and no popcount logic.

## Structure
- Package mb_cam_pkg holds ENTRIES, IDX_W, KEY_MSB = 39, KEY_LSB = 8, IDXF_MSB = 17, and onehot/encode helper functions.
- Sub-module mb_cam_penc: 16-bit lowest-set-bit priority encoder, with any and multi outputs.
  - Instance 1: free-entry selection (on ~valid).
  - Instance 2: hit encoding (on q).

## Test plan
- Reset, then alloc_req with addr 40'h12_3456_7800 -> alloc_gnt = 1, alloc_idx = 0; next cycle cam_adr_w = 16'h0001, cam_write_en = 1; count = 1.
- Fill 16 entries -> full = 1; 17th alloc_req -> alloc_gnt = 0, no CAM write.
- Lookup key 32'h1234_5678 after the write has settled, cam_match = 16'h0001 -> lkup_vld in N+3, lkup_hit = 1, lkup_hit_idx = 0.
- Alloc idx 3 and lookup of the same key in the same cycle, with CAM returning 16'h0000 -> lkup_hit = 1, lkup_hit_idx = 3 (bypass).
- Entry 5 valid, lookup issued, dealloc idx 5 in cycle N+1, CAM returns 16'h0020 -> lkup_hit = 0.
- cam_match = 16'h0300 on valid entries 8 and 9 -> lkup_hit_idx = 8; lkup_err = 1 only with MB_CAM_CTL_MULTIHIT_CHK_EN defined.

Source files
------------

// File: rtl/mb_cam_pkg.sv
// mb_cam_pkg: shared sizes, field positions, lookup context payload and
// one-hot/encode helpers for the miss-buffer CAM controller.
package mb_cam_pkg;

  localparam int unsigned ENTRIES  = 16;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned ADDR_W   = 40;
  localparam int unsigned KEY_MSB  = 39;
  localparam int unsigned KEY_LSB  = 8;
  localparam int unsigned IDXF_MSB = 17;

  // Per-lookup context carried down the pipeline alongside the valid bit.
  typedef struct packed {
    logic [ENTRIES-1:0] vsnap;     // valid bits when the lookup was issued
    logic               byp;       // same-cycle alloc matched the full key
    logic               byp_idxf;  // same-cycle alloc matched the index field
    logic [IDX_W-1:0]   bidx;      // entry granted to that alloc
  } lkup_ctx_t;

  function automatic logic [ENTRIES-1:0] onehot(input logic [IDX_W-1:0] idx);
    return ENTRIES'(1) << idx;
  endfunction

  // Lowest set bit wins; returns 0 for an empty vector.
  function automatic logic [IDX_W-1:0] encode_lsb(input logic [ENTRIES-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mb_cam_penc.sv
// mb_cam_penc: 16-bit lowest-set-bit priority encoder (combinational).
//   i_vec      request vector
//   o_idx_c    index of lowest set bit (0 when none)
//   o_any_c    any bit set
//   o_multi_c  more than one bit set
module mb_cam_penc
  import mb_cam_pkg::*;
(
  input  logic [ENTRIES-1:0] i_vec,
  output logic [IDX_W-1:0]   o_idx_c,
  output logic               o_any_c,
  output logic               o_multi_c
);

  assign o_idx_c   = encode_lsb(i_vec);
  assign o_any_c   = |i_vec;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign o_multi_c = |(i_vec & (i_vec - ENTRIES'(1)));

endmodule

// File: rtl/mb_cam_ctl.sv
// mb_cam_ctl: allocation / lookup controller for the 16 x 40-bit miss-buffer
// address CAM. Tracks entry valids and occupancy, grants the lowest free
// entry, drives the CAM write and lookup ports, and turns the CAM's registered
// match vectors into valid-qualified, priority-encoded hits three cycles after
// each lookup request. A same-cycle alloc/lookup of one key is covered by an
// in-flight bypass.
//
// Ports:
//   rclk, rst_l                    clock, synchronous active-low reset
//   alloc_req/alloc_addr           allocate request and address
//   alloc_gnt/alloc_idx            same-cycle grant and granted entry
//   dealloc_vld/dealloc_idx        free an entry
//   lkup_req/lkup_key              lookup request and key [39:8]
//   lkup_vld/lkup_hit/lkup_hit_idx lookup result, N+3
//   lkup_idx_hit                   any valid entry matches key[17:8]
//   lkup_err                       multi-hit flag
//   count/full                     occupancy
//   cam_write_en/cam_adr_w/cam_din CAM write port
//   cam_lookup_en/cam_key          CAM lookup port
//   cam_match/cam_match_idx        CAM registered match vectors
//
// Build option: define MB_CAM_CTL_MULTIHIT_CHK_EN to enable lkup_err
// multi-hit detection and a simulation report of the hit vector; otherwise
// lkup_err is tied low.
module mb_cam_ctl
  import mb_cam_pkg::*;
(
  input  logic                     rclk,
  input  logic                     rst_l,
  input  logic                     alloc_req,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic                     alloc_gnt,
  output logic [IDX_W-1:0]         alloc_idx,
  input  logic                     dealloc_vld,
  input  logic [IDX_W-1:0]         dealloc_idx,
  input  logic                     lkup_req,
  input  logic [KEY_MSB:KEY_LSB]   lkup_key,
  output logic                     lkup_vld,
  output logic                     lkup_hit,
  output logic [IDX_W-1:0]         lkup_hit_idx,
  output logic                     lkup_idx_hit,
  output logic                     lkup_err,
  output logic [CNT_W-1:0]         count,
  output logic                     full,
  output logic                     cam_write_en,
  output logic [ENTRIES-1:0]       cam_adr_w,
  output logic [ADDR_W-1:0]        cam_din,
  output logic                     cam_lookup_en,
  output logic [KEY_MSB:KEY_LSB]   cam_key,
  input  logic [ENTRIES-1:0]       cam_match,
  input  logic [ENTRIES-1:0]       cam_match_idx
);

  logic [ENTRIES-1:0]     r_valid;
  logic [CNT_W-1:0]       r_count;
  logic                   r_full;
  logic                   r_cam_write_en;
  logic [ENTRIES-1:0]     r_cam_adr_w;
  logic [ADDR_W-1:0]      r_cam_din;
  logic                   r_s1_vld;
  logic [KEY_MSB:KEY_LSB] r_s1_key;
  lkup_ctx_t              r_s1_ctx;
  logic                   r_s2_vld;
  lkup_ctx_t              r_s2_ctx;
  logic                   r_lkup_vld;
  logic                   r_lkup_hit;
  logic [IDX_W-1:0]       r_lkup_hit_idx;
  logic                   r_lkup_idx_hit;

  logic [IDX_W-1:0]       w_free_idx;
  logic                   w_free_any;
  logic                   w_free_multi;
  logic [ENTRIES-1:0]     w_alloc_oh;
  logic                   w_dealloc_hit;
  logic [ENTRIES-1:0]     w_dealloc_oh;
  logic [ENTRIES-1:0]     w_valid_nxt;
  logic [CNT_W-1:0]       w_count_nxt;
  lkup_ctx_t              w_s0_ctx;
  logic [ENTRIES-1:0]     w_byp_oh;
  logic [ENTRIES-1:0]     w_byp_idxf_oh;
  logic [ENTRIES-1:0]     w_q;
  logic [ENTRIES-1:0]     w_q_idx;
  logic [IDX_W-1:0]       w_hit_idx;
  logic                   w_hit_any;
  logic                   w_hit_multi;
  logic                   w_unused_penc;

  // Free-entry selection: lowest clear valid bit.
  mb_cam_penc u_free_penc (
    .i_vec     (~r_valid),
    .o_idx_c   (w_free_idx),
    .o_any_c   (w_free_any),
    .o_multi_c (w_free_multi)
  );

  assign alloc_gnt = alloc_req & ~r_full;
  assign alloc_idx = w_free_idx;

  // Alloc only picks clear entries and dealloc only acts on set ones, so the
  // two masks never overlap.
  always_comb begin
    w_alloc_oh    = alloc_gnt ? onehot(w_free_idx) : '0;
    w_dealloc_hit = dealloc_vld & r_valid[dealloc_idx];
    w_dealloc_oh  = w_dealloc_hit ? onehot(dealloc_idx) : '0;
    w_valid_nxt   = (r_valid | w_alloc_oh) & ~w_dealloc_oh;
    w_count_nxt   = r_count + CNT_W'(alloc_gnt) - CNT_W'(w_dealloc_hit);
  end

  // S0 context: pre-alloc valid snapshot plus same-cycle alloc bypass.
  always_comb begin
    w_s0_ctx          = '0;
    w_s0_ctx.vsnap    = r_valid;
    w_s0_ctx.byp      = alloc_gnt & (alloc_addr[KEY_MSB:KEY_LSB] == lkup_key);
    w_s0_ctx.byp_idxf = alloc_gnt &
                        (alloc_addr[IDXF_MSB:KEY_LSB] == lkup_key[IDXF_MSB:KEY_LSB]);
    w_s0_ctx.bidx     = w_free_idx;
  end

  // CAM match arrives while the lookup is in S2; qualify with the issue-time
  // snapshot (stale writes) and current valids (in-flight deallocs).
  always_comb begin
    w_byp_oh      = (r_s2_ctx.byp && r_valid[r_s2_ctx.bidx]) ?
                    onehot(r_s2_ctx.bidx) : '0;
    w_byp_idxf_oh = (r_s2_ctx.byp_idxf && r_valid[r_s2_ctx.bidx]) ?
                    onehot(r_s2_ctx.bidx) : '0;
    w_q           = '0;
    w_q_idx       = '0;
    if (r_s2_vld) begin
      w_q     = (cam_match     & r_s2_ctx.vsnap & r_valid) | w_byp_oh;
      w_q_idx = (cam_match_idx & r_s2_ctx.vsnap & r_valid) | w_byp_idxf_oh;
    end
  end

  // Hit encoding on the qualified match vector.
  mb_cam_penc u_hit_penc (
    .i_vec     (w_q),
    .o_idx_c   (w_hit_idx),
    .o_any_c   (w_hit_any),
    .o_multi_c (w_hit_multi)
  );

  assign w_unused_penc = ^{w_free_any, w_free_multi, w_hit_multi};

  // State, CAM port and lookup pipeline registers.
  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      r_valid        <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_cam_write_en <= 1'b0;
      r_cam_adr_w    <= '0;
      r_cam_din      <= '0;
      r_s1_vld       <= 1'b0;
      r_s1_key       <= '0;
      r_s1_ctx       <= '0;
      r_s2_vld       <= 1'b0;
      r_s2_ctx       <= '0;
      r_lkup_vld     <= 1'b0;
      r_lkup_hit     <= 1'b0;
      r_lkup_hit_idx <= '0;
      r_lkup_idx_hit <= 1'b0;
    end else begin
      r_valid        <= w_valid_nxt;
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == CNT_W'(ENTRIES));
      r_cam_write_en <= alloc_gnt;
      r_cam_adr_w    <= w_alloc_oh;
      if (alloc_gnt) r_cam_din <= alloc_addr;
      r_s1_vld       <= lkup_req;
      if (lkup_req) begin
        r_s1_key <= lkup_key;
        r_s1_ctx <= w_s0_ctx;
      end
      r_s2_vld       <= r_s1_vld;
      r_s2_ctx       <= r_s1_ctx;
      r_lkup_vld     <= r_s2_vld;
      r_lkup_hit     <= w_hit_any;
      r_lkup_hit_idx <= w_hit_idx;
      r_lkup_idx_hit <= |w_q_idx;
    end
  end

  assign count         = r_count;
  assign full          = r_full;
  assign cam_write_en  = r_cam_write_en;
  assign cam_adr_w     = r_cam_adr_w;
  assign cam_din       = r_cam_din;
  assign cam_lookup_en = r_s1_vld;
  assign cam_key       = r_s1_key;
  assign lkup_vld      = r_lkup_vld;
  assign lkup_hit      = r_lkup_hit;
  assign lkup_hit_idx  = r_lkup_hit_idx;
  assign lkup_idx_hit  = r_lkup_idx_hit;

`ifdef MB_CAM_CTL_MULTIHIT_CHK_EN
  logic r_lkup_err;

  // w_q is zero outside a valid S2, so this is already lkup_vld-qualified.
  always_ff @(posedge rclk) begin
    if (!rst_l) r_lkup_err <= 1'b0;
    else        r_lkup_err <= w_hit_multi;
  end

  assign lkup_err = r_lkup_err;

`ifndef SYNTHESIS
  always @(posedge rclk) begin
    if (rst_l && w_hit_multi) $display("mb_cam_ctl: multi-hit q=%h", w_q);
  end
`endif
`else
  assign lkup_err = 1'b0;
`endif

endmodule

// File: tb/tb_mb_cam_ctl.sv
// tb_mb_cam_ctl: directed bench for mb_cam_ctl. An alloc/dealloc vector table
// covers grant, fill, full and dealloc corner cases; hand sequences cover
// reset, lookup latency, bypass, in-flight dealloc and multi-hit.
module tb_mb_cam_ctl;

  logic        rclk;
  logic        rst_l;
  logic        alloc_req;
  logic [39:0] alloc_addr;
  logic        alloc_gnt;
  logic [3:0]  alloc_idx;
  logic        dealloc_vld;
  logic [3:0]  dealloc_idx;
  logic        lkup_req;
  logic [39:8] lkup_key;
  logic        lkup_vld;
  logic        lkup_hit;
  logic [3:0]  lkup_hit_idx;
  logic        lkup_idx_hit;
  logic        lkup_err;
  logic [4:0]  count;
  logic        full;
  logic        cam_write_en;
  logic [15:0] cam_adr_w;
  logic [39:0] cam_din;
  logic        cam_lookup_en;
  logic [39:8] cam_key;
  logic [15:0] cam_match;
  logic [15:0] cam_match_idx;

`ifdef MB_CAM_CTL_MULTIHIT_CHK_EN
  localparam logic MH_EN = 1'b1;
`else
  localparam logic MH_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mb_cam_ctl dut (
    .rclk          (rclk),
    .rst_l         (rst_l),
    .alloc_req     (alloc_req),
    .alloc_addr    (alloc_addr),
    .alloc_gnt     (alloc_gnt),
    .alloc_idx     (alloc_idx),
    .dealloc_vld   (dealloc_vld),
    .dealloc_idx   (dealloc_idx),
    .lkup_req      (lkup_req),
    .lkup_key      (lkup_key),
    .lkup_vld      (lkup_vld),
    .lkup_hit      (lkup_hit),
    .lkup_hit_idx  (lkup_hit_idx),
    .lkup_idx_hit  (lkup_idx_hit),
    .lkup_err      (lkup_err),
    .count         (count),
    .full          (full),
    .cam_write_en  (cam_write_en),
    .cam_adr_w     (cam_adr_w),
    .cam_din       (cam_din),
    .cam_lookup_en (cam_lookup_en),
    .cam_key       (cam_key),
    .cam_match     (cam_match),
    .cam_match_idx (cam_match_idx)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    logic        a_req;
    logic [39:0] a_addr;
    logic        d_vld;
    logic [3:0]  d_idx;
    logic        e_gnt;
    logic [3:0]  e_idx;
    logic        e_wen;
    logic [15:0] e_adr;
    logic [4:0]  e_cnt;
    logic        e_full;
  } vec_t;

  vec_t tbl [22];

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Lookup in cycle N with optional same-cycle alloc and a dealloc in N+1;
  // the CAM stub returns m/mi in N+2 and the result is checked in N+3.
  task automatic run_lkup(input string nm, input logic [31:0] key,
                          input logic a_req, input logic [39:0] a_addr,
                          input logic d_vld, input logic [3:0] d_idx,
                          input logic [15:0] m, input logic [15:0] mi,
                          input logic e_hit, input logic [3:0] e_idx,
                          input logic e_ih, input logic e_err);
    lkup_req   = 1'b1;
    lkup_key   = key;
    alloc_req  = a_req;
    alloc_addr = a_addr;
    tick();
    lkup_req    = 1'b0;
    alloc_req   = 1'b0;
    dealloc_vld = d_vld;
    dealloc_idx = d_idx;
    chk({nm, ".cam_lookup_en"}, 64'(cam_lookup_en), 64'(1));
    chk({nm, ".cam_key"}, 64'(cam_key), 64'(key));
    tick();
    dealloc_vld   = 1'b0;
    cam_match     = m;
    cam_match_idx = mi;
    chk({nm, ".vld_n2"}, 64'(lkup_vld), 64'(0));
    tick();
    cam_match     = '0;
    cam_match_idx = '0;
    chk({nm, ".vld_n3"}, 64'(lkup_vld), 64'(1));
    chk({nm, ".hit"}, 64'(lkup_hit), 64'(e_hit));
    chk({nm, ".hit_idx"}, 64'(lkup_hit_idx), 64'(e_idx));
    chk({nm, ".idx_hit"}, 64'(lkup_idx_hit), 64'(e_ih));
    chk({nm, ".err"}, 64'(lkup_err), 64'(e_err));
    tick();
    chk({nm, ".vld_n4"}, 64'(lkup_vld), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Fill 16 entries, then full/dealloc corner cases.
    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{1'b1, 40'h12_3456_7800 + (40'(i) << 8), 1'b0, 4'd0,
                 1'b1, 4'(i), 1'b1, 16'(1) << i, 5'(i + 1), (i == 15)};
    end
    tbl[16] = '{1'b1, 40'hAA_0000_0000, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0000, 5'd16, 1'b1};
    tbl[17] = '{1'b0, 40'h00_0000_0000, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 16'h0000, 5'd15, 1'b0};
    tbl[18] = '{1'b1, 40'h55_5555_5500, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 16'h0008, 5'd16, 1'b1};
    tbl[19] = '{1'b0, 40'h00_0000_0000, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0000, 5'd15, 1'b0};
    tbl[20] = '{1'b1, 40'h66_0000_0100, 1'b1, 4'd7, 1'b1, 4'd0, 1'b1, 16'h0001, 5'd15, 1'b0};
    tbl[21] = '{1'b0, 40'h00_0000_0000, 1'b1, 4'd7, 1'b0, 4'd7, 1'b0, 16'h0000, 5'd15, 1'b0};

    rst_l = 1'b0; alloc_req = 1'b0; alloc_addr = '0; dealloc_vld = 1'b0;
    dealloc_idx = '0; lkup_req = 1'b0; lkup_key = '0;
    cam_match = '0; cam_match_idx = '0;
    repeat (3) tick();
    chk("rst.count", 64'(count), 64'(0));
    chk("rst.full", 64'(full), 64'(0));
    chk("rst.cam_write_en", 64'(cam_write_en), 64'(0));
    chk("rst.cam_adr_w", 64'(cam_adr_w), 64'(0));
    chk("rst.cam_lookup_en", 64'(cam_lookup_en), 64'(0));
    chk("rst.lkup_vld", 64'(lkup_vld), 64'(0));
    rst_l = 1'b1;
    tick();

    for (int i = 0; i < 22; i++) begin
      alloc_req   = tbl[i].a_req;
      alloc_addr  = tbl[i].a_addr;
      dealloc_vld = tbl[i].d_vld;
      dealloc_idx = tbl[i].d_idx;
      #1;
      chk($sformatf("v%0d.alloc_gnt", i), 64'(alloc_gnt), 64'(tbl[i].e_gnt));
      chk($sformatf("v%0d.alloc_idx", i), 64'(alloc_idx), 64'(tbl[i].e_idx));
      tick();
      chk($sformatf("v%0d.cam_write_en", i), 64'(cam_write_en), 64'(tbl[i].e_wen));
      chk($sformatf("v%0d.cam_adr_w", i), 64'(cam_adr_w), 64'(tbl[i].e_adr));
      if (tbl[i].e_wen) chk($sformatf("v%0d.cam_din", i), 64'(cam_din), 64'(tbl[i].a_addr));
      chk($sformatf("v%0d.count", i), 64'(count), 64'(tbl[i].e_cnt));
      chk($sformatf("v%0d.full", i), 64'(full), 64'(tbl[i].e_full));
    end
    alloc_req = 1'b0; dealloc_vld = 1'b0;

    // Reset while a lookup is in flight: the result must never appear.
    lkup_req = 1'b1; lkup_key = 32'h0000_0001;
    tick();
    lkup_req = 1'b0;
    chk("rstmid.cam_lookup_en", 64'(cam_lookup_en), 64'(1));
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    chk("rstmid.count", 64'(count), 64'(0));
    chk("rstmid.full", 64'(full), 64'(0));
    chk("rstmid.cam_lookup_en", 64'(cam_lookup_en), 64'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rstmid.lkup_vld%0d", i), 64'(lkup_vld), 64'(0));
    end

    // First alloc after reset, then a settled lookup.
    alloc_req = 1'b1; alloc_addr = 40'h12_3456_7800;
    #1;
    chk("first.alloc_gnt", 64'(alloc_gnt), 64'(1));
    chk("first.alloc_idx", 64'(alloc_idx), 64'(0));
    tick();
    alloc_req = 1'b0;
    chk("first.cam_write_en", 64'(cam_write_en), 64'(1));
    chk("first.cam_adr_w", 64'(cam_adr_w), 64'(16'h0001));
    chk("first.count", 64'(count), 64'(1));
    repeat (2) tick();
    run_lkup("basic", 32'h1234_5678, 1'b0, 40'h0, 1'b0, 4'd0,
             16'h0001, 16'h0001, 1'b1, 4'd0, 1'b1, 1'b0);

    // Entries 1..9, then free 3 so the next alloc lands on 3.
    for (int i = 1; i < 10; i++) begin
      alloc_req = 1'b1; alloc_addr = {32'h2000_0000 + 32'(i), 8'h00};
      tick();
    end
    alloc_req = 1'b0;
    dealloc_vld = 1'b1; dealloc_idx = 4'd3;
    tick();
    dealloc_vld = 1'b0;
    repeat (2) tick();
    chk("setup.count", 64'(count), 64'(9));

    run_lkup("bypass", 32'hCAFE_0123, 1'b1, {32'hCAFE_0123, 8'h55}, 1'b0, 4'd0,
             16'h0000, 16'h0000, 1'b1, 4'd3, 1'b1, 1'b0);
    run_lkup("dealloc_inflight", 32'h2000_0005, 1'b0, 40'h0, 1'b1, 4'd5,
             16'h0020, 16'h0020, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("dealloc_inflight.count", 64'(count), 64'(9));
    run_lkup("idxf_bypass", 32'h0000_0123, 1'b1, {32'hFFFF_0123, 8'h00}, 1'b0, 4'd0,
             16'h0000, 16'h0000, 1'b0, 4'd0, 1'b1, 1'b0);
    run_lkup("multihit", 32'h2000_0008, 1'b0, 40'h0, 1'b0, 4'd0,
             16'h0300, 16'h0300, 1'b1, 4'd8, 1'b1, MH_EN);
    run_lkup("valid_mask", 32'h0000_0000, 1'b0, 40'h0, 1'b0, 4'd0,
             16'h1404, 16'h1000, 1'b1, 4'd2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
